// File: rtl/fasm_fifo_wbw_if.sv
`default_nettype none
// ============================================================================
// Module   : fasm_fifo_wbw_if
// Summary  : Wishbone classic write-only bus bundle for the FIFO drain engine.
// Options  : FASM_WBW_ERR_EN adds the slave error-termination signal err.
// Revision : 1.0 - initial release
// ============================================================================
interface fasm_fifo_wbw_if #(
  parameter int AW = 30,
  parameter int DW = 32
);
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat;
  logic [DW/8-1:0] sel;
  logic            we;
  logic            cyc;
  logic            stb;
  logic            ack;
`ifdef FASM_WBW_ERR_EN
  logic            err;
`endif

  modport master (
    output adr, dat, sel, we, cyc, stb,
`ifdef FASM_WBW_ERR_EN
    input  err,
`endif
    input  ack
  );

  modport slave (
    input  adr, dat, sel, we, cyc, stb,
`ifdef FASM_WBW_ERR_EN
    output err,
`endif
    output ack
  );
endinterface
`default_nettype wire

// File: rtl/fasm_fifo_wbw.sv
`default_nettype none
// ============================================================================
// Module   : fasm_fifo_wbw
// Summary  : Drains a programmed number of FIFO words as Wishbone classic
//            single writes to consecutive (wrapping) word addresses.
// Options  : FASM_WBW_ERR_EN adds wb.err termination and the sticky err_o.
// Revision : 1.0 - initial release
// ============================================================================
module fasm_fifo_wbw #(
  parameter int AW = 30,
  parameter int DW = 32,
  parameter int LW = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ena_i,
  input  logic [AW-1:0]         cfg_adr_i,
  input  logic [LW-1:0]         cfg_len_i,
  input  logic                  cfg_stb_i,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic [DW-1:0]         fifo_dat_i,
  input  logic                  fifo_rok_i,
  output logic                  fifo_rde_o,
`ifdef FASM_WBW_ERR_EN
  output logic                  err_o,
`endif
  fasm_fifo_wbw_if.master       wb
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_BUS   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_adr;
  logic [DW-1:0] r_dat;
  logic [LW-1:0] r_cnt;
  logic          r_cyc;
  logic          r_stb;
  logic          w_err;
  logic          w_term;
  logic          w_last;

`ifdef FASM_WBW_ERR_EN
  logic          r_err;
  assign w_err = wb.err;
`else
  assign w_err = 1'b0;
`endif

  // An error ends the bus word like an ack but also ends the whole transfer.
  assign w_term = wb.ack | w_err;
  assign w_last = (r_cnt == LW'(1)) | w_err;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
    end else if (ena_i) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (cfg_stb_i) begin
          w_state_nxt = (cfg_len_i == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (fifo_rok_i) begin
          w_state_nxt = ST_BUS;
        end
      end
      ST_BUS: begin
        if (w_term) begin
          w_state_nxt = w_last ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_adr <= '0;
      r_dat <= '0;
      r_cnt <= '0;
      r_cyc <= 1'b0;
      r_stb <= 1'b0;
    end else if (ena_i) begin
      case (r_state)
        ST_IDLE: begin
          if (cfg_stb_i) begin
            r_adr <= cfg_adr_i;
            r_cnt <= cfg_len_i;
            r_cyc <= (cfg_len_i != '0);
          end
        end
        ST_FETCH: begin
          if (fifo_rok_i) begin
            r_dat <= fifo_dat_i;
            r_stb <= 1'b1;
          end
        end
        ST_BUS: begin
          if (w_term) begin
            r_stb <= 1'b0;
            r_adr <= r_adr + AW'(1);
            r_cnt <= r_cnt - LW'(1);
            if (w_last) begin
              r_cyc <= 1'b0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef FASM_WBW_ERR_EN
  // Sticky until software starts the next transfer.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_err <= 1'b0;
    end else if (ena_i) begin
      if (r_state == ST_IDLE && cfg_stb_i) begin
        r_err <= 1'b0;
      end else if (r_state == ST_BUS && w_err) begin
        r_err <= 1'b1;
      end
    end
  end
  assign err_o = r_err;
`endif

  assign busy_o     = (r_state != ST_IDLE);
  assign done_o     = (r_state == ST_DONE);
  assign fifo_rde_o = (r_state == ST_FETCH) & fifo_rok_i & ena_i;

  assign wb.adr = r_adr;
  assign wb.dat = r_dat;
  assign wb.sel = '1;
  assign wb.we  = 1'b1;
  assign wb.cyc = r_cyc;
  assign wb.stb = r_stb;

endmodule
`default_nettype wire

// File: tb/tb_fasm_fifo_wbw.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fasm_fifo_wbw
// Summary  : Directed self-checking bench for fasm_fifo_wbw with a FIFO model
//            and a Wishbone slave model (FASM_WBW_ERR_EN optional).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fasm_fifo_wbw;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int LW = 8;

  logic          clk_i     = 1'b0;
  logic          rst_i     = 1'b0;
  logic          ena_i     = 1'b1;
  logic [AW-1:0] cfg_adr_i = '0;
  logic [LW-1:0] cfg_len_i = '0;
  logic          cfg_stb_i = 1'b0;
  logic          busy_o;
  logic          done_o;
  logic [DW-1:0] fifo_dat_i;
  logic          fifo_rok_i;
  logic          fifo_rde_o;
`ifdef FASM_WBW_ERR_EN
  logic          err_o;
`endif

  fasm_fifo_wbw_if #(.AW(AW), .DW(DW)) wb ();

  fasm_fifo_wbw #(.AW(AW), .DW(DW), .LW(LW)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .ena_i      (ena_i),
    .cfg_adr_i  (cfg_adr_i),
    .cfg_len_i  (cfg_len_i),
    .cfg_stb_i  (cfg_stb_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .fifo_dat_i (fifo_dat_i),
    .fifo_rok_i (fifo_rok_i),
    .fifo_rde_o (fifo_rde_o),
`ifdef FASM_WBW_ERR_EN
    .err_o      (err_o),
`endif
    .wb         (wb)
  );

  always #5 clk_i = ~clk_i;

  // Fall-through FIFO model
  logic [DW-1:0] fmem [0:15];
  int unsigned   wr_ptr = 0;
  int unsigned   rd_ptr = 0;
  assign fifo_rok_i = (wr_ptr != rd_ptr);
  assign fifo_dat_i = fmem[rd_ptr[3:0]];

  // Wishbone slave model with programmable ack latency and error injection
  logic ack_en    = 1'b1;
  int   ack_delay = 0;
  int   wait_cnt  = 0;
  logic err_arm   = 1'b0;
  int   err_nw    = 0;
  logic err_act;
  int   n_pop = 0, n_wr = 0, n_done = 0, bad_pop = 0;
  logic [AW-1:0] log_adr [0:63];
  logic [DW-1:0] log_dat [0:63];

  assign err_act = err_arm & wb.cyc & wb.stb & (n_wr == err_nw);
  assign wb.ack  = ack_en & wb.cyc & wb.stb & (wait_cnt >= ack_delay) & ~err_act;
`ifdef FASM_WBW_ERR_EN
  assign wb.err  = err_act;
`endif

  always @(posedge clk_i) begin
    if (fifo_rde_o) begin
      rd_ptr <= rd_ptr + 1;
      n_pop  <= n_pop + 1;
      if (!fifo_rok_i) bad_pop <= bad_pop + 1;
    end
    if (done_o && ena_i) n_done <= n_done + 1;
    if (wb.cyc && wb.stb && wb.ack && ena_i) begin
      log_adr[n_wr[5:0]] <= wb.adr;
      log_dat[n_wr[5:0]] <= wb.dat;
      n_wr <= n_wr + 1;
    end
    wait_cnt <= (wb.stb && !wb.ack) ? wait_cnt + 1 : 0;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    fmem[wr_ptr[3:0]] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic start(input logic [AW-1:0] adr, input logic [LW-1:0] len);
    cfg_adr_i = adr;
    cfg_len_i = len;
    cfg_stb_i = 1'b1;
    tick();
    cfg_stb_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int k = 0;
    while (done_o !== 1'b1 && k < max_cyc) begin
      tick();
      k++;
    end
    chk(tag, done_o, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int b_pop, b_wr, b_done;

    // Reset values
    tick(); tick();
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_cyc",  wb.cyc, 0);
    chk("rst_stb",  wb.stb, 0);
    chk("rst_adr",  wb.adr, 0);
    chk("rst_dat",  wb.dat, 0);
    chk("rst_rde",  fifo_rde_o, 0);
    chk("rst_sel",  wb.sel, 4'hF);
    chk("rst_we",   wb.we, 1);
    rst_i = 1'b1;
    tick();

    // Basic 4-word burst with zero-wait acks
    b_pop = n_pop; b_wr = n_wr; b_done = n_done;
    for (int i = 0; i < 4; i++) push(32'hA0 + i);
    start(30'h100, 8'd4);
    chk("t2_busy", busy_o, 1);
    chk("t2_cyc",  wb.cyc, 1);
    chk("t2_stb0", wb.stb, 0);
    wait_done("t2_done", 40);
    chk("t2_busy_in_done", busy_o, 1);
    chk("t2_cyc_in_done",  wb.cyc, 0);
    tick();
    chk("t2_done_pulse", done_o, 0);
    chk("t2_busy_fall",  busy_o, 0);
    chk("t2_pops",   n_pop - b_pop, 4);
    chk("t2_writes", n_wr - b_wr, 4);
    chk("t2_ndone",  n_done - b_done, 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_adr%0d", i), log_adr[b_wr + i], 30'h100 + i);
      chk($sformatf("t2_dat%0d", i), log_dat[b_wr + i], 32'hA0 + i);
    end

    // Empty-FIFO stall, then slow ack
    ack_delay = 3;
    b_pop = n_pop; b_wr = n_wr;
    start(30'h200, 8'd2);
    tick(); tick(); tick();
    chk("t3_stall_cyc", wb.cyc, 1);
    chk("t3_stall_stb", wb.stb, 0);
    chk("t3_stall_pop", n_pop - b_pop, 0);
    push(32'h55);
    tick();
    chk("t3_stb_rise", wb.stb, 1);
    chk("t3_dat", wb.dat, 32'h55);
    chk("t3_adr", wb.adr, 30'h200);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t3_hold_stb%0d", i), wb.stb, 1);
      chk($sformatf("t3_hold_adr%0d", i), wb.adr, 30'h200);
      chk($sformatf("t3_hold_dat%0d", i), wb.dat, 32'h55);
    end
    tick();
    chk("t3_acked_stb", wb.stb, 0);
    chk("t3_acked_adr", wb.adr, 30'h201);
    push(32'h66);
    wait_done("t3_done", 40);
    tick();
    chk("t3_writes", n_wr - b_wr, 2);
    chk("t3_dat1", log_dat[b_wr + 1], 32'h66);
    chk("t3_adr1", log_adr[b_wr + 1], 30'h201);
    ack_delay = 0;

    // Address wrap at the top of the word space
    b_wr = n_wr;
    push(32'h11); push(32'h22);
    start(30'h3FFF_FFFF, 8'd2);
    wait_done("t4_done", 40);
    tick();
    chk("t4_adr0", log_adr[b_wr],     30'h3FFF_FFFF);
    chk("t4_adr1", log_adr[b_wr + 1], 30'h0);
    chk("t4_dat1", log_dat[b_wr + 1], 32'h22);

    // Zero length: straight to DONE, no bus, no pops
    b_pop = n_pop; b_wr = n_wr;
    start(30'h123, 8'd0);
    chk("t4z_done", done_o, 1);
    chk("t4z_cyc",  wb.cyc, 0);
    chk("t4z_busy", busy_o, 1);
    tick();
    chk("t4z_done_fall", done_o, 0);
    chk("t4z_busy_fall", busy_o, 0);
    chk("t4z_pops", n_pop - b_pop, 0);
    chk("t4z_wr",   n_wr - b_wr, 0);

    // Clock-enable freeze during BUS, then start ignored while busy
    b_wr = n_wr; b_pop = n_pop;
    ack_en = 1'b0;
    push(32'h77); push(32'h88);
    start(30'h300, 8'd2);
    tick();
    chk("t5_bus_stb", wb.stb, 1);
    ena_i = 1'b0; ack_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t5_frz_stb%0d", i), wb.stb, 1);
      chk($sformatf("t5_frz_adr%0d", i), wb.adr, 30'h300);
      chk($sformatf("t5_frz_dat%0d", i), wb.dat, 32'h77);
    end
    chk("t5_frz_wr", n_wr - b_wr, 0);
    ena_i = 1'b1;
    tick();
    chk("t5_resume_adr", wb.adr, 30'h301);
    chk("t5_resume_stb", wb.stb, 0);
    start(30'h3AB, 8'd9);
    wait_done("t5_done", 40);
    tick();
    chk("t5_busy_end", busy_o, 0);
    chk("t5_wr",       n_wr - b_wr, 2);
    chk("t5_pops",     n_pop - b_pop, 2);
    chk("t5_adr1",     log_adr[b_wr + 1], 30'h301);
    chk("t5_dat1",     log_dat[b_wr + 1], 32'h88);
    chk("t5_adr_end",  wb.adr, 30'h302);

    // Asynchronous reset in the middle of a bus word
    ack_en = 1'b0;
    push(32'h99);
    start(30'h400, 8'd1);
    tick();
    chk("t1_pre_stb", wb.stb, 1);
    #2;
    rst_i = 1'b0;
    #1;
    chk("t1_cyc",  wb.cyc, 0);
    chk("t1_stb",  wb.stb, 0);
    chk("t1_busy", busy_o, 0);
    chk("t1_adr",  wb.adr, 0);
    chk("t1_dat",  wb.dat, 0);
    chk("t1_done", done_o, 0);
    tick();
    rst_i = 1'b1; ack_en = 1'b1;
    tick();

`ifdef FASM_WBW_ERR_EN
    // Error on the second word terminates the transfer
    b_pop = n_pop; b_wr = n_wr; b_done = n_done;
    for (int i = 0; i < 4; i++) push(32'hC0 + i);
    err_nw  = n_wr + 1;
    err_arm = 1'b1;
    start(30'h500, 8'd4);
    wait_done("t6_done", 40);
    chk("t6_pops",  n_pop - b_pop, 2);
    chk("t6_wr",    n_wr - b_wr, 1);
    chk("t6_err",   err_o, 1);
    chk("t6_adr",   wb.adr, 30'h502);
    chk("t6_cyc",   wb.cyc, 0);
    tick();
    err_arm = 1'b0;
    chk("t6_ndone", n_done - b_done, 1);
    chk("t6_err_sticky", err_o, 1);
    start(30'h600, 8'd0);
    chk("t6_err_clr", err_o, 0);
    tick();
`endif

    chk("no_pop_when_empty", bad_pop, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
